logic_issue: RTL and testbench

//  Issue/retire stage wrapped around the 64-bit logic unit (AND/OR/XOR/NOT).

---
 rtl/logic_issue.sv | 158 +++++++++++++++
 tb/tb_logic_issue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_issue.sv
// Issue/retire wrapper for the 64-bit logic unit: input queue, credit-limited issue,
// destination-tag pipe matching the unit latency, and an in-order result queue.
module logic_issue #(
   parameter int IQ_DEPTH = 4,
   parameter int RQ_DEPTH = 4,
   parameter int LU_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_ctrl,
   input  logic [63:0] in_op1,
   input  logic [63:0] in_op2,
   input  logic [4:0]  in_rd,
   output logic [1:0]  lu_ctrl,
   output logic [63:0] lu_op1,
   output logic [63:0] lu_op2,
   input  logic [63:0] lu_dst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_rd,
   output logic [63:0] out_data,
   output logic        busy
);
   localparam int IQ_AW = $clog2(IQ_DEPTH);
   localparam int RQ_AW = $clog2(RQ_DEPTH);
   localparam int IQ_CW = IQ_AW + 1;
   localparam int RQ_CW = RQ_AW + 1;

   logic [1:0]       iq_ctrl_q [IQ_DEPTH];
   logic [1:0]       iq_ctrl_d [IQ_DEPTH];
   logic [63:0]      iq_op1_q  [IQ_DEPTH];
   logic [63:0]      iq_op1_d  [IQ_DEPTH];
   logic [63:0]      iq_op2_q  [IQ_DEPTH];
   logic [63:0]      iq_op2_d  [IQ_DEPTH];
   logic [4:0]       iq_rd_q   [IQ_DEPTH];
   logic [4:0]       iq_rd_d   [IQ_DEPTH];
   logic [IQ_AW-1:0] iq_head_q, iq_head_d, iq_tail_q, iq_tail_d;
   logic [IQ_CW-1:0] iq_count_q, iq_count_d;

   logic [1:0]       lu_ctrl_q, lu_ctrl_d;
   logic [63:0]      lu_op1_q, lu_op1_d, lu_op2_q, lu_op2_d;

   logic [LU_LAT:0]  tag_vld_q, tag_vld_d;
   logic [4:0]       tag_rd_q [LU_LAT+1];
   logic [4:0]       tag_rd_d [LU_LAT+1];

   logic [4:0]       rq_rd_q   [RQ_DEPTH];
   logic [4:0]       rq_rd_d   [RQ_DEPTH];
   logic [63:0]      rq_data_q [RQ_DEPTH];
   logic [63:0]      rq_data_d [RQ_DEPTH];
   logic [RQ_AW-1:0] rq_head_q, rq_head_d, rq_tail_q, rq_tail_d;
   logic [RQ_CW-1:0] rq_count_q, rq_count_d;

   logic       iq_push, issue, rq_push, rq_pop;
   logic [7:0] inflight;

   assign in_ready  = !rst && (iq_count_q < IQ_CW'(IQ_DEPTH));
   assign out_valid = (rq_count_q != '0);
   assign out_rd    = rq_rd_q[rq_head_q];
   assign out_data  = rq_data_q[rq_head_q];
   assign busy      = (iq_count_q != '0) || (inflight != '0) || (rq_count_q != '0);
   assign lu_ctrl   = lu_ctrl_q;
   assign lu_op1    = lu_op1_q;
   assign lu_op2    = lu_op2_q;

   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LU_LAT; i++) inflight = inflight + 8'(tag_vld_q[i]);

      iq_push = in_valid && in_ready;
      // Credit counts every tag in the pipe, so the result queue can never overflow.
      issue   = (iq_count_q != '0) &&
                ((32'(inflight) + 32'(rq_count_q)) < 32'(RQ_DEPTH));
      rq_push = tag_vld_q[LU_LAT];
      rq_pop  = out_valid && out_ready;

      iq_ctrl_d  = iq_ctrl_q;
      iq_op1_d   = iq_op1_q;
      iq_op2_d   = iq_op2_q;
      iq_rd_d    = iq_rd_q;
      iq_head_d  = iq_head_q;
      iq_tail_d  = iq_tail_q;
      lu_ctrl_d  = lu_ctrl_q;
      lu_op1_d   = lu_op1_q;
      lu_op2_d   = lu_op2_q;
      rq_rd_d    = rq_rd_q;
      rq_data_d  = rq_data_q;
      rq_head_d  = rq_head_q;
      rq_tail_d  = rq_tail_q;

      if (iq_push) begin
         iq_ctrl_d[iq_tail_q] = in_ctrl;
         iq_op1_d[iq_tail_q]  = in_op1;
         iq_op2_d[iq_tail_q]  = in_op2;
         iq_rd_d[iq_tail_q]   = in_rd;
         iq_tail_d            = iq_tail_q + IQ_AW'(1);
      end
      if (issue) begin
         lu_ctrl_d = iq_ctrl_q[iq_head_q];
         lu_op1_d  = iq_op1_q[iq_head_q];
         lu_op2_d  = iq_op2_q[iq_head_q];
         iq_head_d = iq_head_q + IQ_AW'(1);
      end
      iq_count_d = iq_count_q + IQ_CW'(iq_push) - IQ_CW'(issue);

      tag_vld_d[0] = issue;
      tag_rd_d[0]  = iq_rd_q[iq_head_q];
      for (int i = 1; i <= LU_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_rd_d[i]  = tag_rd_q[i-1];
      end

      if (rq_push) begin
         rq_rd_d[rq_tail_q]   = tag_rd_q[LU_LAT];
         rq_data_d[rq_tail_q] = lu_dst;
         rq_tail_d            = rq_tail_q + RQ_AW'(1);
      end
      if (rq_pop) rq_head_d = rq_head_q + RQ_AW'(1);
      rq_count_d = rq_count_q + RQ_CW'(rq_push) - RQ_CW'(rq_pop);
   end

   always_ff @(posedge clk) begin
      iq_ctrl_d_to_q: begin
         iq_ctrl_q <= iq_ctrl_d;
         iq_op1_q  <= iq_op1_d;
         iq_op2_q  <= iq_op2_d;
         iq_rd_q   <= iq_rd_d;
         tag_rd_q  <= tag_rd_d;
         rq_rd_q   <= rq_rd_d;
         rq_data_q <= rq_data_d;
      end
      if (rst) begin
         iq_head_q  <= '0;
         iq_tail_q  <= '0;
         iq_count_q <= '0;
         lu_ctrl_q  <= '0;
         lu_op1_q   <= '0;
         lu_op2_q   <= '0;
         tag_vld_q  <= '0;
         rq_head_q  <= '0;
         rq_tail_q  <= '0;
         rq_count_q <= '0;
      end else begin
         iq_head_q  <= iq_head_d;
         iq_tail_q  <= iq_tail_d;
         iq_count_q <= iq_count_d;
         lu_ctrl_q  <= lu_ctrl_d;
         lu_op1_q   <= lu_op1_d;
         lu_op2_q   <= lu_op2_d;
         tag_vld_q  <= tag_vld_d;
         rq_head_q  <= rq_head_d;
         rq_tail_q  <= rq_tail_d;
         rq_count_q <= rq_count_d;
      end
   end
endmodule

// File: tb/tb_logic_issue.sv
// Directed bench for logic_issue with a one-cycle logic unit model in the loop and an
// in-order scoreboard of {rd, result} filled at each accepted handshake.
module tb_logic_issue;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [1:0]  in_ctrl;
   logic [63:0] in_op1, in_op2;
   logic [4:0]  in_rd;
   logic [1:0]  lu_ctrl;
   logic [63:0] lu_op1, lu_op2, lu_dst;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic [63:0] out_data;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int retired = 0;
   int acc_cnt = 0;
   int first_ret = 0;
   int last_ret = 0;
   logic [68:0] exp_q [$];

   always #5 clk = ~clk;

   logic_issue #(.IQ_DEPTH(4), .RQ_DEPTH(4), .LU_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
      .in_op1(in_op1), .in_op2(in_op2), .in_rd(in_rd),
      .lu_ctrl(lu_ctrl), .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_dst(lu_dst),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
      .out_data(out_data), .busy(busy)
   );

   function automatic logic [63:0] lu_model(input logic [1:0] c, input logic [63:0] a,
                                            input logic [63:0] b);
      case (c)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   always_ff @(posedge clk) lu_dst <= lu_model(lu_ctrl, lu_op1, lu_op2);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score the handshakes that the coming edge will complete, then step.
   task automatic tick();
      logic acc, ret;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
         if (exp_q.size() == 0) check("unexpected_result", 64'(out_valid), 64'd0);
         else begin
            check("out_rd", 64'(out_rd), 64'(exp_q[0][68:64]));
            check("out_data", out_data, exp_q[0][63:0]);
            void'(exp_q.pop_front());
            retired++;
            if (retired == 1) first_ret = cyc;
            last_ret = cyc;
         end
      end
      if (acc) begin
         exp_q.push_back({in_rd, lu_model(in_ctrl, in_op1, in_op2)});
         acc_cnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input int k);
      in_valid = 1'b1;
      in_ctrl  = 2'(k % 4);
      in_op1   = 64'h0123_4567_89AB_CDEF ^ (64'(k) * 64'h1111_0000_1111);
      in_op2   = {32'hFFFF_0000, 32'(k) * 32'h0101_0101};
      in_rd    = 5'(k);
   endtask

   task automatic drain(input int budget);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) tick();
   endtask

   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b1; in_ctrl = 2'd1; in_op1 = 64'hAAAA; in_op2 = 64'h5555;
      in_rd = 5'd9; out_ready = 1'b0;
      #1;

      // Reset holds everything idle even with a valid offer.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_in_ready", 64'(in_ready), 64'd0);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
      end
      check("rst_lu_op1", lu_op1, 64'd0);
      check("rst_lu_ctrl", 64'(lu_ctrl), 64'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Single AND op: result visible three edges after the accept edge.
      out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 2'd0; in_op1 = 64'hF0F0; in_op2 = 64'hFF00; in_rd = 5'd3;
      tick();
      in_valid = 1'b0;
      check("lat_e0", 64'(out_valid), 64'd0);
      tick();
      check("lat_e1", 64'(out_valid), 64'd0);
      tick();
      check("lat_e2", 64'(out_valid), 64'd0);
      tick();
      check("lat_e3_valid", 64'(out_valid), 64'd1);
      check("lat_e3_data", out_data, 64'hF000);
      check("lat_e3_rd", 64'(out_rd), 64'd3);
      tick();
      check("single_done_valid", 64'(out_valid), 64'd0);
      check("single_done_busy", 64'(busy), 64'd0);

      // Eight back-to-back ops, one result per cycle once the pipe fills.
      retired = 0;
      for (int k = 0; k < 8; k++) begin
         send(k);
         check("b2b_in_ready", 64'(in_ready), 64'd1);
         tick();
      end
      drain(30);
      check("b2b_retired", 64'(retired), 64'd8);
      check("b2b_rate", 64'(last_ret - first_ret), 64'd7);
      check("b2b_empty", 64'(exp_q.size()), 64'd0);

      // Backpressure: 4 results plus 4 queued ops, then in_ready drops.
      retired = 0;
      out_ready = 1'b0;
      base = acc_cnt;
      for (int i = 0; i < 14; i++) begin
         send(20 + acc_cnt - base);
         tick();
      end
      check("bp_accepted", 64'(acc_cnt - base), 64'd8);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_iq_count", 64'(dut.iq_count_q), 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 40 && (acc_cnt - base < 10 || exp_q.size() != 0); i++) begin
         if (acc_cnt - base < 10) send(20 + acc_cnt - base);
         else in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      check("bp_total_accepted", 64'(acc_cnt - base), 64'd10);
      check("bp_retired", 64'(retired), 64'd10);

      // Reset with three ops in flight drops them all.
      for (int k = 0; k < 3; k++) begin
         send(40 + k);
         tick();
      end
      in_valid = 1'b0;
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("post_rst_out_valid", 64'(out_valid), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("no_stale_result", 64'(out_valid), 64'd0);
      end

      // Steady accept+issue with three ops parked in the input queue.
      out_ready = 1'b0;
      base = acc_cnt;
      for (int i = 0; i < 20 && acc_cnt - base < 7; i++) begin
         send(50 + acc_cnt - base);
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("steady_pre_iq", 64'(dut.iq_count_q), 64'd3);
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         send(60 + i);
         tick();
         check("steady_iq_count", 64'(dut.iq_count_q), 64'd3);
         check("steady_in_ready", 64'(in_ready), 64'd1);
      end
      drain(60);
      check("steady_empty", 64'(exp_q.size()), 64'd0);
      check("final_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
